// File: rtl/rom_load_ctrl.sv
// ROM download and core start-up sequencer: forwards ioctl ROM bytes, owns variant/DIP registers.
// Define ROM_LOAD_CHECKSUM_EN to build the additive ROM checksum; otherwise rom_sum reads 0.
module rom_load_ctrl #(
    parameter int unsigned ROM_SIZE   = 65536,
    parameter int unsigned WR_STRETCH = 2,
    parameter int unsigned RESET_HOLD = 64,
    parameter logic [63:0] DIP_INIT   = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    input  logic        reset_req,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic [7:0]  mod_sel,
    output logic [63:0] dip_bank,
    output logic        rom_loaded,
    output logic        wr_overrun,
    output logic        addr_oob,
    output logic [7:0]  rom_sum
);

    typedef enum logic [1:0] {StBoot, StLoad, StHold, StRun} state_e;

    state_e       state_q, state_d;
    logic [15:0]  hold_cnt_q, hold_cnt_d;
    logic [3:0]   stretch_q, stretch_d;
    logic [16:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0]  dn_addr_q, dn_addr_d;
    logic [7:0]   dn_data_q, dn_data_d;
    logic [7:0]   mod_sel_q, mod_sel_d;
    logic [63:0]  dip_q, dip_d;
    logic         loaded_q, loaded_d;
    logic         overrun_q, overrun_d;
    logic         oob_q, oob_d;

    logic rom_strobe, in_range, stretch_busy, accept, dl_start, load_done, enter_load;

    assign dl_start     = ioctl_download && (ioctl_index == 8'd0);
    assign load_done    = !ioctl_download && (stretch_q == 4'd0);
    assign rom_strobe   = (state_q == StLoad) && ioctl_wr && (ioctl_index == 8'd0);
    assign in_range     = ioctl_addr < 25'(ROM_SIZE);
    // A count of 1 expires on this edge, so the next byte may follow with no gap.
    assign stretch_busy = stretch_q > 4'd1;
    assign accept       = rom_strobe && in_range && !stretch_busy;
    assign enter_load   = (state_d == StLoad) && (state_q != StLoad);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot: if (dl_start) state_d = StLoad;
            StLoad: if (load_done) state_d = (byte_cnt_q != 17'd0) ? StHold : StBoot;
            StHold: begin
                if (dl_start) state_d = StLoad;
                else if (!reset_req && hold_cnt_q == 16'd0) state_d = StRun;
            end
            StRun: begin
                if (dl_start) state_d = StLoad;
                else if (reset_req) state_d = StHold;
            end
            default: state_d = StBoot;
        endcase
    end

    always_comb begin
        core_reset = (state_q != StRun);
        dn_wr      = (stretch_q != 4'd0);
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        stretch_d  = stretch_q;
        byte_cnt_d = byte_cnt_q;
        dn_addr_d  = dn_addr_q;
        dn_data_d  = dn_data_q;
        mod_sel_d  = mod_sel_q;
        dip_d      = dip_q;
        loaded_d   = loaded_q;
        overrun_d  = overrun_q;
        oob_d      = oob_q;

        if (state_d == StHold && (state_q != StHold || reset_req)) begin
            hold_cnt_d = 16'(RESET_HOLD - 1);
        end else if (state_q == StHold && hold_cnt_q != 16'd0) begin
            hold_cnt_d = hold_cnt_q - 16'd1;
        end

        if (accept) begin
            stretch_d = 4'(WR_STRETCH);
            dn_addr_d = ioctl_addr[15:0];
            dn_data_d = ioctl_dout;
            if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 17'd1;
        end else if (stretch_q != 4'd0) begin
            stretch_d = stretch_q - 4'd1;
        end

        if (enter_load) begin
            byte_cnt_d = 17'd0;
            loaded_d   = 1'b0;
            overrun_d  = 1'b0;
            oob_d      = 1'b0;
        end else if (rom_strobe && !in_range) begin
            oob_d = 1'b1;
        end else if (rom_strobe && stretch_busy) begin
            overrun_d = 1'b1;
        end

        if (state_q == StLoad && state_d == StHold) loaded_d = 1'b1;

        if (ioctl_wr && ioctl_index == 8'd1) mod_sel_d = ioctl_dout;
        if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr[24:3] == 22'd0) begin
            dip_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q <= 16'd0;
            stretch_q  <= 4'd0;
            byte_cnt_q <= 17'd0;
            dn_addr_q  <= 16'd0;
            dn_data_q  <= 8'd0;
            mod_sel_q  <= 8'd0;
            dip_q      <= DIP_INIT;
            loaded_q   <= 1'b0;
            overrun_q  <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            stretch_q  <= stretch_d;
            byte_cnt_q <= byte_cnt_d;
            dn_addr_q  <= dn_addr_d;
            dn_data_q  <= dn_data_d;
            mod_sel_q  <= mod_sel_d;
            dip_q      <= dip_d;
            loaded_q   <= loaded_d;
            overrun_q  <= overrun_d;
            oob_q      <= oob_d;
        end
    end

`ifdef ROM_LOAD_CHECKSUM_EN
    logic [7:0] rom_sum_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rom_sum_q <= 8'd0;
        end else if (enter_load) begin
            rom_sum_q <= 8'd0;
        end else if (accept) begin
            rom_sum_q <= rom_sum_q + ioctl_dout;
        end
    end

    assign rom_sum = rom_sum_q;
`else
    assign rom_sum = 8'h00;
`endif

    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign mod_sel    = mod_sel_q;
    assign dip_bank   = dip_q;
    assign rom_loaded = loaded_q;
    assign wr_overrun = overrun_q;
    assign addr_oob   = oob_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Randomized self-checking bench for rom_load_ctrl against a transaction-level reference model.
module tb_rom_load_ctrl;

    localparam int unsigned RomSize = 16;
    localparam int unsigned Stretch = 2;
    localparam int unsigned Hold    = 8;
    localparam logic [63:0] DipInit = 64'h0123_4567_89AB_CDEF;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download, ioctl_wr, reset_req;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout, ioctl_index;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data, mod_sel, rom_sum;
    logic        dn_wr, core_reset, rom_loaded, wr_overrun, addr_oob;
    logic [63:0] dip_bank;

    rom_load_ctrl #(
        .ROM_SIZE  (RomSize),
        .WR_STRETCH(Stretch),
        .RESET_HOLD(Hold),
        .DIP_INIT  (DipInit)
    ) u_dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_index   (ioctl_index),
        .reset_req     (reset_req),
        .dn_addr       (dn_addr),
        .dn_data       (dn_data),
        .dn_wr         (dn_wr),
        .core_reset    (core_reset),
        .mod_sel       (mod_sel),
        .dip_bank      (dip_bank),
        .rom_loaded    (rom_loaded),
        .wr_overrun    (wr_overrun),
        .addr_oob      (addr_oob),
        .rom_sum       (rom_sum)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state
    int          last_acc;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data, exp_mod, exp_sum;
    logic [63:0] exp_dip;
    logic        exp_run, exp_loaded, exp_ovr, exp_oob;

    // Byte list consumed by run_load: address, data, cycles to next strobe
    logic [24:0] q_addr[$];
    logic [7:0]  q_data[$];
    int          q_gap[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        last_acc   = -1000;
        exp_addr   = '0;
        exp_data   = '0;
        exp_mod    = '0;
        exp_sum    = '0;
        exp_dip    = DipInit;
        exp_run    = 1'b0;
        exp_loaded = 1'b0;
        exp_ovr    = 1'b0;
        exp_oob    = 1'b0;
    endtask

    task automatic check_wr();
        check_eq("dn_wr", dn_wr, (cyc - last_acc) < int'(Stretch));
        check_eq("dn_addr", dn_addr, exp_addr);
        check_eq("dn_data", dn_data, exp_data);
    endtask

    task automatic check_status();
        check_eq("core_reset", core_reset, !exp_run);
        check_eq("rom_loaded", rom_loaded, exp_loaded);
        check_eq("wr_overrun", wr_overrun, exp_ovr);
        check_eq("addr_oob", addr_oob, exp_oob);
`ifdef ROM_LOAD_CHECKSUM_EN
        check_eq("rom_sum", rom_sum, exp_sum);
`else
        check_eq("rom_sum", rom_sum, 8'h00);
`endif
    endtask

    task automatic wait_release(input string tag);
        int n = 0;
        while (core_reset && n < int'(Hold) + 10) begin
            step();
            n++;
        end
        check_eq(tag, n, Hold);
        exp_run = 1'b1;
    endtask

    // Plays the queued bytes as one download and checks the outcome.
    task automatic run_load();
        int any = 0;
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        step();
        exp_run = 1'b0; exp_loaded = 1'b0; exp_ovr = 1'b0; exp_oob = 1'b0; exp_sum = '0;
        check_eq("core_reset_load", core_reset, 1'b1);
        while (q_addr.size() > 0) begin
            logic [24:0] a = q_addr.pop_front();
            logic [7:0]  d = q_data.pop_front();
            int          g = q_gap.pop_front();
            ioctl_addr = a;
            ioctl_dout = d;
            ioctl_wr   = 1'b1;
            step();
            ioctl_wr = 1'b0;
            if (a >= 25'(RomSize)) exp_oob = 1'b1;
            else if (cyc - last_acc < int'(Stretch)) exp_ovr = 1'b1;
            else begin
                last_acc = cyc;
                exp_addr = a[15:0];
                exp_data = d;
                exp_sum  = exp_sum + d;
                any++;
            end
            check_wr();
            for (int i = 1; i < g; i++) begin
                step();
                check_wr();
            end
        end
        for (int i = 0; i < int'(Stretch); i++) begin
            step();
            check_wr();
        end
        ioctl_download = 1'b0;
        step();
        check_wr();
        exp_loaded = (any > 0);
        check_status();
        if (any > 0) begin
            wait_release("release_after_load");
        end else begin
            for (int i = 0; i < int'(Hold) + 2; i++) step();
            check_eq("boot_stays_reset", core_reset, 1'b1);
        end
    endtask

    task automatic reg_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_download = 1'b1;
        ioctl_index    = idx;
        ioctl_addr     = a;
        ioctl_dout     = d;
        ioctl_wr       = 1'b1;
        step();
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        if (idx == 8'd1) exp_mod = d;
        if (idx == 8'd254 && a < 25'd8) exp_dip[a[2:0]*8 +: 8] = d;
        check_eq("mod_sel", mod_sel, exp_mod);
        check_eq("dip_bank", dip_bank, exp_dip);
        check_eq("core_reset_regwr", core_reset, !exp_run);
    endtask

    initial begin
        reset_n = 1'b0;
        ioctl_download = 1'b0; ioctl_wr = 1'b0; reset_req = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
        model_reset();
        #12;
        check_eq("rst_dn_wr", dn_wr, 1'b0);
        check_eq("rst_dn_addr", dn_addr, 16'h0);
        check_eq("rst_dn_data", dn_data, 8'h0);
        check_eq("rst_mod_sel", mod_sel, 8'h0);
        check_eq("rst_dip", dip_bank, DipInit);
        check_status();
        reset_n = 1'b1;
        step(); step();
        check_eq("boot_idle", core_reset, 1'b1);

        // Basic load: four bytes, spacing 4
        for (int i = 0; i < 4; i++) begin
            q_addr.push_back(25'(i));
            q_data.push_back(8'(8'h10 * (i + 1)));
            q_gap.push_back(4);
        end
        run_load();
`ifdef ROM_LOAD_CHECKSUM_EN
        check_eq("basic_sum", rom_sum, 8'hA0);
`endif

        // Variant and DIP writes in RUN, with a non-ROM download active
        reg_write(8'd1, 25'd0, 8'h0B);
        reg_write(8'd254, 25'd2, 8'h5A);
        reg_write(8'd254, 25'd9, 8'h77);
        check_eq("dip_byte2", dip_bank[23:16], 8'h5A);

        // User reset held for 10 cycles
        reset_req = 1'b1;
        step();
        check_eq("user_reset_rise", core_reset, 1'b1);
        for (int i = 1; i < 10; i++) step();
        reset_req = 1'b0;
        wait_release("release_after_user_reset");

        // Overrun: second strobe one cycle after the first
        q_addr.push_back(25'd0); q_data.push_back(8'hC3); q_gap.push_back(1);
        q_addr.push_back(25'd1); q_data.push_back(8'h3C); q_gap.push_back(1);
        run_load();
        check_eq("overrun_flag", wr_overrun, 1'b1);

        // Out of range only: back to BOOT
        q_addr.push_back(25'(RomSize)); q_data.push_back(8'h99); q_gap.push_back(2);
        run_load();
        check_eq("oob_flag", addr_oob, 1'b1);

        // Randomized loads and register writes
        for (int it = 0; it < 10; it++) begin
            int n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                int r = int'($urandom_range(0, 9));
                if (r == 0) q_addr.push_back(25'h100_0000 | 25'($urandom_range(0, 15)));
                else if (r == 1) q_addr.push_back(25'($urandom_range(RomSize, 40)));
                else q_addr.push_back(25'($urandom_range(0, RomSize - 1)));
                q_data.push_back(8'($urandom));
                q_gap.push_back(int'($urandom_range(1, 3)));
            end
            run_load();
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 1) == 0) reg_write(8'd1, 25'($urandom), 8'($urandom));
                else reg_write(8'd254, 25'($urandom_range(0, 11)), 8'($urandom));
            end
        end

        // Async reset in the middle of a stretch
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        step();
        ioctl_addr = 25'd5; ioctl_dout = 8'hE7; ioctl_wr = 1'b1;
        step();
        ioctl_wr = 1'b0;
        check_eq("pre_async_dn_wr", dn_wr, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_dn_wr", dn_wr, 1'b0);
        model_reset();
        ioctl_download = 1'b0;
        step();
        reset_n = 1'b1;
        step(); step();
        check_status();
        check_eq("async_dip", dip_bank, DipInit);
        check_eq("async_mod_sel", mod_sel, 8'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
